// File: rtl/branch_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit saturating counters,
// trained by branches resolved in EX, with misprediction detection and redirect.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
    input  logic [31:0] upd_pred_target_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [15:0] mispred_cnt_o
);
    localparam int TAG_W = 30 - IDX_W;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [15:0]      r_mis_cnt;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic [31:0]      w_pc_plus4;

    logic [IDX_W-1:0] w_upd_idx;
    logic [TAG_W-1:0] w_upd_tag;
    logic             w_upd_hit;
    logic             w_upd_act;
    logic [31:0]      w_upd_plus4;
    logic [31:0]      w_actual;
    logic [31:0]      w_predicted;

    // Fetch-side lookup: always reads the table contents from before this cycle's update
    assign w_idx         = pc_i[IDX_W+1:2];
    assign w_tag         = pc_i[31:IDX_W+2];
    assign w_pc_plus4    = pc_i + 32'd4;
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign pred_taken_o  = w_hit && r_ctr[w_idx][1] && start_i && rst_n_i;
    assign pred_target_o = w_hit ? r_target[w_idx] : w_pc_plus4;

    assign w_upd_idx     = upd_pc_i[IDX_W+1:2];
    assign w_upd_tag     = upd_pc_i[31:IDX_W+2];
    assign w_upd_hit     = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_upd_act     = upd_valid_i && start_i && rst_n_i;
    assign w_upd_plus4   = upd_pc_i + 32'd4;
    assign w_actual      = upd_taken_i      ? upd_target_i      : w_upd_plus4;
    assign w_predicted   = upd_pred_taken_i ? upd_pred_target_i : w_upd_plus4;

    assign mispredict_o  = w_upd_act && (w_actual != w_predicted);
    assign redirect_pc_o = w_upd_act ? w_actual : w_upd_plus4;
    assign pc_next_o     = mispredict_o ? redirect_pc_o :
                           pred_taken_o ? pred_target_o : w_pc_plus4;
    assign mispred_cnt_o = r_mis_cnt;

    // BTB training from resolved branches; not-taken misses leave the table alone
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 32'd0;
                r_ctr[i]    <= 2'b01;
            end
        end else if (w_upd_act) begin
            if (w_upd_hit) begin
                if (upd_taken_i) begin
                    r_target[w_upd_idx] <= upd_target_i;
                    if (r_ctr[w_upd_idx] != 2'b11) begin
                        r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
                    end
                end else if (r_ctr[w_upd_idx] != 2'b00) begin
                    r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= upd_target_i;
                r_ctr[w_upd_idx]    <= 2'b10;
            end
        end
    end

    // Saturating misprediction counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_mis_cnt <= 16'd0;
        end else if (mispredict_o && (r_mis_cnt != 16'hFFFF)) begin
            r_mis_cnt <= r_mis_cnt + 16'd1;
        end
    end

endmodule
